// File: rtl/stream_frame_checker.sv
// Framing checker and registered pipeline stage for a sop/eop/val/rdy stream.
// Drops orphan beats, truncates over-length packets and reports each packet's length on its eop beat.
//
// state   | meaning
// IDLE    | between packets; a beat without sop is an orphan
// IN_PKT  | inside a packet; cnt holds the words forwarded so far
// DISCARD | packet was truncated; drop beats until eop or a new sop
module stream_frame_checker #(
    parameter int BITS      = 8,
    parameter int MAX_WORDS = 1500,
    parameter int LEN_BITS  = 12
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                din_val,
    input  logic                din_sop,
    input  logic                din_eop,
    input  logic [BITS-1:0]     din,
    output logic                din_rdy,
    input  logic                dout_rdy,
    output logic                dout_val,
    output logic                dout_sop,
    output logic                dout_eop,
    output logic [BITS-1:0]     dout,
    output logic [LEN_BITS-1:0] dout_len,
    output logic                dout_err,
    output logic                err_orphan,
    output logic                err_noeop,
    output logic                err_trunc,
    output logic [15:0]         pkt_cnt
);

    localparam logic [LEN_BITS-1:0] MAX_CNT = LEN_BITS'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

    state_t              state, state_nxt;
    logic [LEN_BITS-1:0] cnt, cnt_nxt, cnt_new, len_nxt;
    logic                acc, fwd, start;
    logic                eop_nxt, err_nxt;
    logic                orphan_nxt, noeop_nxt, trunc_nxt;

    assign din_rdy = ~dout_val | dout_rdy;
    assign acc     = din_val & din_rdy;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cnt_new    = '0;
        len_nxt    = '0;
        fwd        = 1'b0;
        start      = 1'b0;
        eop_nxt    = din_eop;
        err_nxt    = 1'b0;
        orphan_nxt = 1'b0;
        noeop_nxt  = 1'b0;
        trunc_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (din_sop) start = 1'b1;
                else         orphan_nxt = 1'b1;
            end
            IN_PKT: begin
                if (din_sop) begin
                    start     = 1'b1;
                    noeop_nxt = 1'b1;
                end else begin
                    fwd     = 1'b1;
                    cnt_new = cnt + LEN_BITS'(1);
                end
            end
            DISCARD: begin
                if (din_sop)      start     = 1'b1;
                else if (din_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A sop always opens a fresh packet, whatever came before it.
        if (start) begin
            fwd     = 1'b1;
            cnt_new = LEN_BITS'(1);
        end

        if (fwd) begin
            if (din_eop) begin
                len_nxt   = cnt_new;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else if (cnt_new == MAX_CNT) begin
                eop_nxt   = 1'b1;
                err_nxt   = 1'b1;
                len_nxt   = MAX_CNT;
                trunc_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = DISCARD;
            end else begin
                cnt_nxt   = cnt_new;
                state_nxt = IN_PKT;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (acc) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output register: reload on a forwarded beat, otherwise empty once transferred.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout     <= '0;
            dout_len <= '0;
            dout_err <= 1'b0;
        end else if (acc && fwd) begin
            dout_val <= 1'b1;
            dout_sop <= din_sop;
            dout_eop <= eop_nxt;
            dout     <= din;
            dout_len <= len_nxt;
            dout_err <= err_nxt;
        end else if (dout_rdy) begin
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_len <= '0;
            dout_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            err_orphan <= 1'b0;
            err_noeop  <= 1'b0;
            err_trunc  <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            err_orphan <= acc & orphan_nxt;
            err_noeop  <= acc & noeop_nxt;
            err_trunc  <= acc & trunc_nxt;
            if (dout_val && dout_rdy && dout_eop) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

endmodule

// File: doc/stream_frame_checker.md
# stream_frame_checker

Packet-framing checker and registered pipeline stage that sits directly downstream of the 0-latency stream adapter. It consumes the adapter's sop/eop/val/rdy stream and enforces well-formed framing: orphan beats are dropped, over-length packets are truncated, and each packet's word count is reported on its eop beat. It adds one register stage with full-throughput backpressure, so downstream timing is isolated from the adapter's combinational output mux.

## Interface
- BITS, 8, data width.
- MAX_WORDS, 1500, maximum packet length in words; legal range 1 .. 2^LEN_BITS-1.
- LEN_BITS, 12, width of dout_len.
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  reset, asynchronous, active-high. One clock domain; asynchronous active-high reset.
- din_val, din_sop, din_eop  in  1 each  input beat qualifiers.
- din  in  BITS  input data.
- din_rdy  out  1  input ready. A beat transfers when din_val & din_rdy (ready latency 0).
- dout_rdy  in  1  downstream ready (ready latency 0).
- dout_val, dout_sop, dout_eop  out  1 each  output beat qualifiers.
- dout  out  BITS  output data.
- dout_len  out  LEN_BITS  packet word count; valid only when dout_val & dout_eop, otherwise 0.
- dout_err  out  1  set on an eop beat whose eop was forced by truncation.
- err_orphan, err_noeop, err_trunc  out  1 each  single-cycle status pulses.
- pkt_cnt  out  16  count of eop beats emitted; wraps at 2^16.

## Operation
- Output register: {dout, sop, eop, len, err, val}. din_rdy = ~dout_val | dout_rdy, with no combinational dependence on din_val.
- Accepted beats are either forwarded (loaded into the output register) or dropped (consumed, never emitted).
- Word counter cnt (LEN_BITS) holds the words forwarded so far in the current packet.
- FSM states: IDLE (between packets), IN_PKT, DISCARD.
- IDLE, accepted beat:
  - With sop: forward it, cnt=1, go to IN_PKT.
  - sop & eop: one-word packet. Forward with len=1 and stay in IDLE.
  - Without sop: drop it, pulse err_orphan, stay in IDLE.
- IN_PKT, accepted beat:
  - No sop, no eop: forward it, cnt+1.
  - eop without sop: forward it, len=cnt+1, go to IDLE.
  - sop: the previous packet lost its eop. Pulse err_noeop, then treat the beat as in IDLE (new packet, cnt=1). The earlier packet is not closed retroactively.
- Truncation, checked in IN_PKT or on a sop beat:
  - Applies when a forwarded beat would make the count equal MAX_WORDS and din_eop=0.
  - The beat is forwarded with eop forced to 1, len=MAX_WORDS and dout_err=1.
  - err_trunc pulses and the FSM goes to DISCARD.
  - If din_eop=1 at exactly MAX_WORDS, the packet ends normally with no error.
  - MAX_WORDS=1: every sop-without-eop beat is truncated.
- DISCARD, accepted beat:
  - Without sop: drop it. If it carries eop, go to IDLE.
  - With sop: handle as in IDLE (new packet) with no error pulse.
- pkt_cnt increments by 1 on each output transfer (dout_val & dout_rdy & dout_eop).
- Status pulses are asserted in the cycle after the acceptance that caused them (registered), for exactly one cycle.

## Timing
- Latency: a forwarded beat appears on dout one clock after acceptance.
- Throughput: 1 beat/clock while dout_rdy=1.
- Stall behaviour:
  - While dout_val & ~dout_rdy, the output register and din_rdy=0 hold.
  - Dropped beats also wait for din_rdy, so dropping never bypasses a stall.
- Simultaneous output and input transfer in the same clock: the register reloads with the new beat and dout_val stays 1.
- Accepted but dropped beat while dout_rdy=1: dout_val goes to 0 next clock.
- dout_val must not depend on dout_rdy, and once asserted, output contents stay stable until transferred.
- Reset, asynchronous:
  - Values: dout_val=0, dout_sop=0, dout_eop=0, dout=0, dout_len=0, dout_err=0, all err_* =0, pkt_cnt=0, cnt=0, FSM=IDLE.
  - Reset mid-packet discards the held beat and partial count. The first post-reset beat is judged from IDLE.
  - din_rdy=1 from the first clock after reset deasserts.

## Test plan
- Clean traffic, dout_rdy=1: 3-word packet {sop,-,eop} then 1-word {sop+eop} -> same beats, 1-clock latency, len=3 then 1, dout_err=0, pkt_cnt=2.
- Orphans: 2 beats with no sop in IDLE, then a 2-word packet -> both orphans dropped, err_orphan pulses twice, only the packet emitted, len=2.
- Truncation, MAX_WORDS=4: 7-word packet -> 4 beats out, 4th with eop=1, len=4, dout_err=1. Words 5-7 dropped, err_trunc pulses once. The next sop packet passes normally.
- Exact-max edge, MAX_WORDS=4: 4-word packet ending in eop -> len=4, dout_err=0, no err_trunc.
- Missing eop: sop,w,sop,w,eop -> all 5 beats forwarded, err_noeop pulses once, final eop len=3.
- Backpressure and reset:
  - Random dout_rdy (≈50%) over 1000 random well-formed packets -> output stream identical to input, no loss or duplication, data stable during stalls.
  - Assert srst mid-packet -> all outputs 0 immediately; the next sop packet is emitted correctly.
